// File: rtl/interval_capture.sv
// Measures clock cycles from a start rising edge to the next stop rising edge.
// The result is held behind a valid/ack handshake. Define INTERVAL_CAPTURE_RESTART_EN to let a start edge during counting restart the measurement.
module interval_capture #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         ack,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] value,
  output logic         ovf
);

  // One state bit per output, so busy/valid come straight from flops with no decode.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         ovf_flag_q, ovf_flag_d;
  logic [N-1:0] value_q, value_d;
  logic         ovf_q, ovf_d;
  logic         start_r_q, stop_r_q;
  logic         start_e, stop_e;

  assign start_e = start & ~start_r_q;
  assign stop_e  = stop & ~stop_r_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    value_d    = value_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_e) begin
          cnt_d      = CNT_ONE;
          ovf_flag_d = 1'b0;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        if (stop_e) begin
          value_d = cnt_q;
          ovf_d   = ovf_flag_q;
          state_d = DONE;
        end
`ifdef INTERVAL_CAPTURE_RESTART_EN
        else if (start_e) begin
          cnt_d      = CNT_ONE;
          ovf_flag_d = 1'b0;
        end
`endif
        else if (cnt_q == CNT_MAX) begin
          ovf_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      value_q    <= '0;
      ovf_q      <= 1'b0;
      start_r_q  <= 1'b0;
      stop_r_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      value_q    <= value_d;
      ovf_q      <= ovf_d;
      start_r_q  <= start;
      stop_r_q   <= stop;
    end
  end

  assign busy  = state_q[0];
  assign valid = state_q[1];
  assign value = value_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_interval_capture.sv
// Directed table-driven bench for interval_capture (N=3), plus a hand-written reset sequence.
module tb_interval_capture;

  logic       clk, rst, start, stop, ack;
  logic       busy, valid, ovf;
  logic [2:0] value;

  interval_capture #(.N(3)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ack(ack),
    .busy(busy), .valid(valid), .value(value), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INTERVAL_CAPTURE_RESTART_EN
  localparam logic [2:0] RVAL = 3'd4;
`else
  localparam logic [2:0] RVAL = 3'd6;
`endif

  typedef struct {
    logic       s, p, a;
    logic       b, v;
    logic [2:0] val;
    logic       o;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(logic s, logic p, logic a, logic b, logic v,
                              logic [2:0] val, logic o);
    vec_t t;
    t.s = s; t.p = p; t.a = a; t.b = b; t.v = v; t.val = val; t.o = o;
    vq.push_back(t);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, logic b, logic v, logic [2:0] val, logic o);
    chk("busy", idx, {31'd0, busy}, {31'd0, b});
    chk("valid", idx, {31'd0, valid}, {31'd0, v});
    chk("value", idx, {29'd0, value}, {29'd0, val});
    chk("ovf", idx, {31'd0, ovf}, {31'd0, o});
  endtask

  task automatic step(logic s, logic p, logic a);
    start = s; stop = p; ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
    // Basic interval, D=5, then hold and ack
    add(1,0,0, 1,0,0,0);
    add(1,0,0, 1,0,0,0);
    add(0,0,0, 1,0,0,0);
    add(0,0,0, 1,0,0,0);
    add(0,0,0, 1,0,0,0);
    add(0,1,0, 0,1,5,0);
    add(0,1,0, 0,1,5,0);
    add(0,0,1, 0,0,5,0);
    // Overflow, D=9
    add(1,0,0, 1,0,5,0);
    for (int i = 0; i < 8; i++) add(0,0,0, 1,0,5,0);
    add(0,1,0, 0,1,7,1);
    add(0,0,1, 0,0,7,1);
    // Exactly full scale, D=7
    add(1,0,0, 1,0,7,1);
    for (int i = 0; i < 6; i++) add(0,0,0, 1,0,7,1);
    add(0,1,0, 0,1,7,0);
    add(0,0,1, 0,0,7,0);
    // Coincident start/stop in IDLE, stop again 2 edges later
    add(1,1,0, 1,0,7,0);
    add(1,0,0, 1,0,7,0);
    add(1,1,0, 0,1,2,0);
    add(0,0,1, 0,0,2,0);
    // Lone stop edge and stray ack in IDLE
    add(0,1,0, 0,0,2,0);
    add(0,0,1, 0,0,2,0);
    // Minimum interval D=1, then DONE held while inputs toggle
    add(1,0,0, 1,0,2,0);
    add(0,1,0, 0,1,1,0);
    add(1,0,0, 0,1,1,0);
    add(0,1,0, 0,1,1,0);
    add(1,0,0, 0,1,1,0);
    add(1,1,0, 0,1,1,0);
    add(1,0,1, 0,0,1,0);
    add(1,0,0, 0,0,1,0);
    add(0,0,0, 0,0,1,0);
    // Start re-pulsed during COUNT
    add(1,0,0, 1,0,1,0);
    add(0,0,0, 1,0,1,0);
    add(1,0,0, 1,0,1,0);
    add(0,0,0, 1,0,1,0);
    add(0,0,0, 1,0,1,0);
    add(0,0,0, 1,0,1,0);
    add(0,1,0, 0,1,RVAL,0);
    add(0,0,1, 0,0,RVAL,0);

    #12;
    chk_all(-1, 0, 0, 3'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(0,0,0);
    chk_all(0, 0, 0, 3'd0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].s, vq[i].p, vq[i].a);
      chk_all(i + 1, vq[i].b, vq[i].v, vq[i].val, vq[i].o);
    end

    // Asynchronous reset mid-COUNT, then restart with start already high at release
    step(1,0,0);
    step(0,0,0);
    step(0,0,0);
    chk_all(100, 1, 0, RVAL, 0);
    #2 rst = 1'b0;
    #1 chk_all(101, 0, 0, 3'd0, 0);
    @(posedge clk);
    #1 start = 1'b1;
    chk_all(102, 0, 0, 3'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1,0,0);
    chk_all(103, 1, 0, 3'd0, 0);
    step(1,0,0);
    step(1,0,0);
    chk_all(104, 1, 0, 3'd0, 0);
    step(1,1,0);
    chk_all(105, 0, 1, 3'd3, 0);
    step(0,0,1);
    chk_all(106, 0, 0, 3'd3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
